// File: rtl/sqrt_calc_param_pkg.sv
// Shared types for the iterative square-root unit: FSM state encoding and
// the root-width derivation used by the top and the iteration step.
package sqrt_pkg;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_CALC = 2'd1,
    SQ_DONE = 2'd2
  } sq_state_e;

  // Root width is half the operand width; operand width must be even.
  function automatic int sqrt_out_w(input int in_w);
    return in_w / 2;
  endfunction

endpackage

// File: rtl/sqrt_calc_param_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
// Consumes the next operand bit pair and yields the next remainder and root.
module sqrt_step #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W+1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       pair_i,
  output logic [OUT_W+1:0] rem_o,
  output logic [OUT_W-1:0] root_o
);

  logic [OUT_W+1:0] trial;
  logic [OUT_W+1:0] test;
  logic             take;

  // The remainder never exceeds 2*root, so dropping the top two bits on the
  // shift loses nothing.
  always_comb begin
    trial  = (rem_i << 2) | {{OUT_W{1'b0}}, pair_i};
    test   = {root_i, 2'b01};
    take   = (trial >= test);
    rem_o  = take ? (trial - test) : trial;
    root_o = {root_i[OUT_W-2:0], take};
  end

endmodule

// File: rtl/sqrt_calc_param.sv
// Iterative integer square root, one root bit per clock, with floor remainder
// and optional signed-operand error reporting. Round-to-nearest on the root
// output is enabled by defining SQRT_CALC_ROUND_EN.
module sqrt_calc_param
  import sqrt_pkg::*;
#(
  parameter  int IN_W      = 16,
  parameter  int SIGNED_IN = 0,
  localparam int OUT_W     = sqrt_out_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W:0]   rem,
  output logic             error,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [OUT_W-1:0] ROOT_MAX = {OUT_W{1'b1}};

  sq_state_e        state_q, state_d;
  logic [IN_W-1:0]  op_q, op_d;
  logic [OUT_W+1:0] rem_acc_q, rem_acc_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W:0]   rem_q, rem_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [OUT_W+1:0] step_rem;
  logic [OUT_W-1:0] step_root;
  logic [OUT_W-1:0] root_final;
  logic             neg_in;

  sqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem_i  (rem_acc_q),
    .root_i (root_q),
    .pair_i (op_q[IN_W-1:IN_W-2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign neg_in = (SIGNED_IN != 0) && in[IN_W-1];

`ifdef SQRT_CALC_ROUND_EN
  // Round up when the remainder exceeds the floor root, saturating at full scale.
  always_comb begin
    root_final = root_q;
    if ((rem_acc_q > {2'b00, root_q}) && (root_q != ROOT_MAX)) begin
      root_final = root_q + 1'b1;
    end
  end
`else
  assign root_final = root_q;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_acc_d = rem_acc_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_d     = out_q;
    rem_d     = rem_q;
    error_d   = error_q;
    done_d    = 1'b0;
    busy_d    = (state_q != SQ_IDLE);

    case (state_q)
      SQ_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (neg_in) begin
            err_d   = 1'b1;
            state_d = SQ_DONE;
          end else begin
            err_d     = 1'b0;
            op_d      = in;
            rem_acc_d = '0;
            root_d    = '0;
            cnt_d     = CNT_W'(OUT_W - 1);
            state_d   = SQ_CALC;
          end
        end
      end
      SQ_CALC: begin
        rem_acc_d = step_rem;
        root_d    = step_root;
        op_d      = {op_q[IN_W-3:0], 2'b00};
        if (cnt_q == '0) begin
          state_d = SQ_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SQ_DONE: begin
        done_d  = 1'b1;
        state_d = SQ_IDLE;
        if (err_q) begin
          out_d   = '0;
          rem_d   = '0;
          error_d = 1'b1;
        end else begin
          out_d   = root_final;
          rem_d   = rem_acc_q[OUT_W:0];
          error_d = 1'b0;
        end
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SQ_IDLE;
      op_q      <= '0;
      rem_acc_q <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_q     <= '0;
      rem_q     <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_acc_q <= rem_acc_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_q     <= out_d;
      rem_q     <= rem_d;
      error_q   <= error_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign out   = out_q;
  assign rem   = rem_q;
  assign error = error_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sqrt_calc_param.sv
// Directed bench for sqrt_calc_param: default 16-bit unit, signed-input unit
// and a 32-bit unit sharing one clock and reset.
module tb_sqrt_calc_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        u_start, u_error, u_done, u_busy;
  logic [15:0] u_in;
  logic [7:0]  u_out;
  logic [8:0]  u_rem;

  logic        s_start, s_error, s_done, s_busy;
  logic [15:0] s_in;
  logic [7:0]  s_out;
  logic [8:0]  s_rem;

  logic        w_start, w_error, w_done, w_busy;
  logic [31:0] w_in;
  logic [15:0] w_out;
  logic [16:0] w_rem;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef SQRT_CALC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  sqrt_calc_param #(.IN_W(16), .SIGNED_IN(0)) u_dut (
    .clk(clk), .rst(rst), .start(u_start), .in(u_in), .out(u_out),
    .rem(u_rem), .error(u_error), .done(u_done), .busy(u_busy));

  sqrt_calc_param #(.IN_W(16), .SIGNED_IN(1)) s_dut (
    .clk(clk), .rst(rst), .start(s_start), .in(s_in), .out(s_out),
    .rem(s_rem), .error(s_error), .done(s_done), .busy(s_busy));

  sqrt_calc_param #(.IN_W(32), .SIGNED_IN(0)) w_dut (
    .clk(clk), .rst(rst), .start(w_start), .in(w_in), .out(w_out),
    .rem(w_rem), .error(w_error), .done(w_done), .busy(w_busy));

  task automatic start_u(input logic [15:0] v);
    @(negedge clk);
    u_in = v; u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0;
  endtask

  task automatic start_s(input logic [15:0] v);
    @(negedge clk);
    s_in = v; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic start_w(input logic [31:0] v);
    @(negedge clk);
    w_in = v; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
  endtask

  // Edges until done is seen after the current point, -1 if it never comes.
  task automatic wait_u(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (u_done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_s(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (s_done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_w(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (w_done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({u_out, u_rem, u_error, u_done, u_busy} !== '0) $display("FAIL reset_u: out=%0d rem=%0d err=%0b done=%0b busy=%0b required all 0", u_out, u_rem, u_error, u_done, u_busy);
    else pass_cnt++;
    total_cnt++;
    if ({s_out, s_rem, s_error, s_done, s_busy} !== '0) $display("FAIL reset_s: out=%0d rem=%0d err=%0b done=%0b busy=%0b required all 0", s_out, s_rem, s_error, s_done, s_busy);
    else pass_cnt++;
    total_cnt++;
    if ({w_out, w_rem, w_error, w_done, w_busy} !== '0) $display("FAIL reset_w: out=%0d rem=%0d err=%0b done=%0b busy=%0b required all 0", w_out, w_rem, w_error, w_done, w_busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    // operand, floor root, floor remainder, rounded root
    int vec [6][4] = '{
      '{0,     0,   0,   0},
      '{200,   14,  4,   14},
      '{211,   14,  15,  15},
      '{65535, 255, 510, 255},
      '{1,     1,   0,   1},
      '{255,   15,  30,  16}
    };
    int n, exp_out;
    for (int v = 0; v < 6; v++) begin
      exp_out = ROUND ? vec[v][3] : vec[v][1];
      start_u(16'(vec[v][0]));
      wait_u(n);
      total_cnt++;
      if (n !== 9) $display("FAIL latency in=%0d: got %0d cycles required 9", vec[v][0], n);
      else pass_cnt++;
      total_cnt++;
      if (u_out !== 8'(exp_out)) $display("FAIL out in=%0d: got %0d required %0d", vec[v][0], u_out, exp_out);
      else pass_cnt++;
      total_cnt++;
      if (u_rem !== 9'(vec[v][2])) $display("FAIL rem in=%0d: got %0d required %0d", vec[v][0], u_rem, vec[v][2]);
      else pass_cnt++;
      total_cnt++;
      if (u_error !== 1'b0) $display("FAIL error in=%0d: got %0b required 0", vec[v][0], u_error);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (u_done !== 1'b0 || u_out !== 8'(exp_out)) $display("FAIL hold in=%0d: done=%0b out=%0d required done=0 out=%0d", vec[v][0], u_done, u_out, exp_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy();
    int n;
    start_u(16'd16);
    total_cnt++;
    if (u_busy !== 1'b0) $display("FAIL busy_start_edge: got %0b required 0", u_busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (u_busy !== 1'b1) $display("FAIL busy_rise: got %0b required 1", u_busy);
    else pass_cnt++;
    wait_u(n);
    total_cnt++;
    if (n !== 8 || u_busy !== 1'b1 || u_out !== 8'd4) $display("FAIL busy_done: cycles=%0d busy=%0b out=%0d required 8/1/4", n, u_busy, u_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (u_busy !== 1'b0) $display("FAIL busy_fall: got %0b required 0", u_busy);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int n, extra;
    start_u(16'd200);
    repeat (2) @(posedge clk);
    @(negedge clk);
    u_in = 16'd16; u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0;
    wait_u(n);
    total_cnt++;
    if (n !== 6 || u_out !== 8'd14 || u_rem !== 9'd4) $display("FAIL ignore_start: cycles=%0d out=%0d rem=%0d required 6/14/4", n, u_out, u_rem);
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (u_done === 1'b1) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ignore_no_queue: got %0d extra done pulses required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    start_u(16'd200);
    wait_u(n);
    total_cnt++;
    if (n !== 9 || u_out !== 8'd14) $display("FAIL b2b_first: cycles=%0d out=%0d required 9/14", n, u_out);
    else pass_cnt++;
    u_in = 16'd16; u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0;
    total_cnt++;
    if (u_done !== 1'b0 || u_busy !== 1'b0) $display("FAIL b2b_gap: done=%0b busy=%0b required 0/0", u_done, u_busy);
    else pass_cnt++;
    wait_u(n);
    total_cnt++;
    if (n !== 9 || u_out !== 8'd4 || u_rem !== 9'd0) $display("FAIL b2b_second: cycles=%0d out=%0d rem=%0d required 9/4/0", n, u_out, u_rem);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, seen;
    start_u(16'd200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({u_out, u_rem, u_error, u_done, u_busy} !== '0) $display("FAIL reset_mid: out=%0d rem=%0d err=%0b done=%0b busy=%0b required all 0", u_out, u_rem, u_error, u_done, u_busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (u_done === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_mid_no_done: got %0d done pulses required 0", seen);
    else pass_cnt++;
    start_u(16'd211);
    wait_u(n);
    total_cnt++;
    if (n !== 9 || u_out !== (ROUND ? 8'd15 : 8'd14) || u_rem !== 9'd15) $display("FAIL reset_mid_fresh: cycles=%0d out=%0d rem=%0d required 9/%0d/15", n, u_out, u_rem, ROUND ? 15 : 14);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int n;
    start_s(16'h7FFF);
    wait_s(n);
    total_cnt++;
    if (n !== 9 || s_out !== 8'd181 || s_rem !== 9'd6 || s_error !== 1'b0) $display("FAIL signed_pos: cycles=%0d out=%0d rem=%0d err=%0b required 9/181/6/0", n, s_out, s_rem, s_error);
    else pass_cnt++;
    start_s(16'h8000);
    wait_s(n);
    total_cnt++;
    if (n !== 1) $display("FAIL signed_neg_latency: got %0d cycles required 1", n);
    else pass_cnt++;
    total_cnt++;
    if (s_error !== 1'b1 || s_out !== 8'd0 || s_rem !== 9'd0) $display("FAIL signed_neg: err=%0b out=%0d rem=%0d required 1/0/0", s_error, s_out, s_rem);
    else pass_cnt++;
    @(posedge clk); #1;
    start_s(16'd16);
    wait_s(n);
    total_cnt++;
    if (n !== 9 || s_out !== 8'd4 || s_rem !== 9'd0 || s_error !== 1'b0) $display("FAIL signed_after_err: cycles=%0d out=%0d rem=%0d err=%0b required 9/4/0/0", n, s_out, s_rem, s_error);
    else pass_cnt++;
  endtask

  task automatic test_wide();
    int n;
    start_w(32'hFFFF_FFFF);
    wait_w(n);
    total_cnt++;
    if (n !== 17) $display("FAIL wide_latency: got %0d cycles required 17", n);
    else pass_cnt++;
    total_cnt++;
    if (w_out !== 16'd65535 || w_rem !== 17'd131070) $display("FAIL wide_max: out=%0d rem=%0d required 65535/131070", w_out, w_rem);
    else pass_cnt++;
    @(posedge clk); #1;
    start_w(32'd1000000);
    wait_w(n);
    total_cnt++;
    if (n !== 17 || w_out !== 16'd1000 || w_rem !== 17'd0) $display("FAIL wide_1e6: cycles=%0d out=%0d rem=%0d required 17/1000/0", n, w_out, w_rem);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    u_start = 1'b0; u_in = '0;
    s_start = 1'b0; s_in = '0;
    w_start = 1'b0; w_in = '0;
    test_reset();
    test_vectors();
    test_busy();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
